// File: rtl/gpio_input_ctrl.sv
// rtl/gpio_input_ctrl.sv - GPIO input synchronizer, debouncer, edge detector and W1C status with irq
module gpio_input_ctrl #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INIVAL   = {WIDTH{1'b0}},
    parameter int               DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    input  logic             tick,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] status,
    output logic             irq
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [7:0]       cnt [WIDTH];
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] set;

    // An event fires on the tick that completes DEBOUNCE consecutive mismatches.
    always_comb begin
        evt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            evt[i] = tick && (s2[i] != level_out[i]) && (cnt[i] == CNT_LAST);
        end
        set = ((evt & s2) & rise_en) | ((evt & ~s2) & fall_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= INIVAL;
            s2        <= INIVAL;
            level_out <= INIVAL;
            status    <= '0;
            irq       <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= 8'd0;
            end
        end else begin
            s1 <= async_in;
            s2 <= s1;
            for (int i = 0; i < WIDTH; i++) begin
                if (tick) begin
                    if (s2[i] == level_out[i]) begin
                        cnt[i] <= 8'd0;
                    end else if (evt[i]) begin
                        cnt[i]       <= 8'd0;
                        level_out[i] <= s2[i];
                    end else begin
                        cnt[i] <= cnt[i] + 8'd1;
                    end
                end
            end
            // Set has priority over a same-cycle clear.
            status <= set | (status & ~clr);
            irq    <= |(status & irq_mask);
        end
    end

endmodule
